// File: rtl/arc4_crack_ctrl.sv
// arc4_crack_ctrl: steps a 24-bit ARC4 key through [KEY_FIRST, KEY_LAST],
// sequencing init/KSA/PRGA per candidate and stopping at the first key whose
// decrypted message is entirely printable ASCII.
module arc4_crack_ctrl #(
  parameter logic [23:0] KEY_FIRST = 24'h000000,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  output logic [23:0] ksa_key,
  output logic [23:0] prga_key,
  input  logic [7:0]  init_s_addr,
  input  logic [7:0]  init_s_wrdata,
  input  logic        init_s_wren,
  input  logic [7:0]  ksa_s_addr,
  input  logic [7:0]  ksa_s_wrdata,
  input  logic        ksa_s_wren,
  input  logic [7:0]  prga_s_addr,
  input  logic [7:0]  prga_s_wrdata,
  input  logic        prga_s_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  pt_addr,
  input  logic [7:0]  pt_wrdata,
  input  logic        pt_wren
);

  localparam int unsigned KEY_W = 24;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PRINT_MIN = 8'h20;
  localparam logic [BYTE_W-1:0] PRINT_MAX = 8'h7E;

  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, CHECK, DONE
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   bad;
  logic   armed;
  logic   in_wait;
  logic   pt_bad;

  assign ksa_key  = key;
  assign prga_key = key;

  assign in_wait = (state == INIT_WAIT) || (state == KSA_WAIT) || (state == PRGA_WAIT);
  assign pt_bad  = pt_wren && (pt_addr != BYTE_W'(0)) &&
                   ((pt_wrdata < PRINT_MIN) || (pt_wrdata > PRINT_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; armed masks the first cycle of every WAIT state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (en) state_nxt = INIT_GO;
      INIT_GO:    state_nxt = INIT_WAIT;
      INIT_WAIT:  if (armed && init_rdy) state_nxt = KSA_GO;
      KSA_GO:     state_nxt = KSA_WAIT;
      KSA_WAIT:   if (armed && ksa_rdy) state_nxt = PRGA_GO;
      PRGA_GO:    state_nxt = PRGA_WAIT;
      PRGA_WAIT:  if (armed && prga_rdy) state_nxt = CHECK;
      CHECK: begin
        if (!bad || (key == KEY_LAST)) state_nxt = DONE;
        else                           state_nxt = INIT_GO;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and S-memory port mux
  always_comb begin
    rdy      = 1'b0;
    init_en  = 1'b0;
    ksa_en   = 1'b0;
    prga_en  = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    unique case (state)
      IDLE, DONE: rdy = 1'b1;
      INIT_GO, INIT_WAIT: begin
        init_en  = (state == INIT_GO);
        s_addr   = init_s_addr;
        s_wrdata = init_s_wrdata;
        s_wren   = init_s_wren;
      end
      KSA_GO, KSA_WAIT: begin
        ksa_en   = (state == KSA_GO);
        s_addr   = ksa_s_addr;
        s_wrdata = ksa_s_wrdata;
        s_wren   = ksa_s_wren;
      end
      PRGA_GO, PRGA_WAIT: begin
        prga_en  = (state == PRGA_GO);
        s_addr   = prga_s_addr;
        s_wrdata = prga_s_wrdata;
        s_wren   = prga_s_wren;
      end
      default: ;
    endcase
  end

  // Candidate key, verdict flags and plaintext snoop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key       <= KEY_FIRST;
      key_valid <= 1'b0;
      bad       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      armed <= in_wait;
      unique case (state)
        IDLE, DONE: begin
          if (en) begin
            key       <= KEY_FIRST;
            key_valid <= 1'b0;
            bad       <= 1'b0;
          end
        end
        PRGA_WAIT: if (pt_bad) bad <= 1'b1;
        CHECK: begin
          if (!bad) begin
            key_valid <= 1'b1;
          end else if (key == KEY_LAST) begin
            key_valid <= 1'b0;
          end else begin
            key <= key + KEY_W'(1);
            bad <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Directed bench for arc4_crack_ctrl with behavioural init/KSA/PRGA models.
module tb_arc4_crack_ctrl;

  localparam logic [23:0] K_FIRST = 24'h000000;
  localparam logic [23:0] K_LAST  = 24'h000003;
  localparam int unsigned BOUND   = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy, key_valid, init_en, ksa_en, prga_en;
  logic [23:0] key, ksa_key, prga_key;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;
  logic [7:0]  pt_addr, pt_wrdata;
  logic        pt_wren;

  // PRGA message pattern: target key gets tb1/tb2, all others ob1/ob2
  logic [23:0] tgt = 24'h0;
  logic [7:0]  len = 8'h02;
  logic [7:0]  tb1 = 8'h41, tb2 = 8'h41, ob1 = 8'h41, ob2 = 8'h41;

  int init_cnt, ksa_cnt, prga_cnt;
  int n_init;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arc4_crack_ctrl #(.KEY_FIRST(K_FIRST), .KEY_LAST(K_LAST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .ksa_key(ksa_key), .prga_key(prga_key),
    .init_s_addr(8'h20), .init_s_wrdata(8'hA1), .init_s_wren(1'b1),
    .ksa_s_addr(8'h10), .ksa_s_wrdata(8'hB2), .ksa_s_wren(1'b1),
    .prga_s_addr(8'h30), .prga_s_wrdata(8'hC3), .prga_s_wren(1'b1),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  // Init model: 3-cycle latency
  always @(posedge clk) begin
    if (!rst_n) begin init_rdy <= 1'b1; init_cnt <= 0; end
    else if (init_en) begin init_rdy <= 1'b0; init_cnt <= 3; end
    else if (init_cnt > 1) init_cnt <= init_cnt - 1;
    else if (init_cnt == 1) begin init_rdy <= 1'b1; init_cnt <= 0; end
  end

  // KSA model: 5-cycle latency
  always @(posedge clk) begin
    if (!rst_n) begin ksa_rdy <= 1'b1; ksa_cnt <= 0; end
    else if (ksa_en) begin ksa_rdy <= 1'b0; ksa_cnt <= 5; end
    else if (ksa_cnt > 1) ksa_cnt <= ksa_cnt - 1;
    else if (ksa_cnt == 1) begin ksa_rdy <= 1'b1; ksa_cnt <= 0; end
  end

  // PRGA model: 4-cycle latency, writes length then two message bytes
  always @(posedge clk) begin
    if (!rst_n) begin prga_rdy <= 1'b1; prga_cnt <= 0; end
    else if (prga_en) begin prga_rdy <= 1'b0; prga_cnt <= 4; end
    else if (prga_cnt > 1) prga_cnt <= prga_cnt - 1;
    else if (prga_cnt == 1) begin prga_rdy <= 1'b1; prga_cnt <= 0; end
  end

  always_comb begin
    pt_wren   = (prga_cnt >= 2);
    pt_addr   = 8'(4 - prga_cnt);
    pt_wrdata = 8'h00;
    if (pt_wren) begin
      case (pt_addr)
        8'd0:    pt_wrdata = len;
        8'd1:    pt_wrdata = (prga_key == tgt) ? tb1 : ob1;
        default: pt_wrdata = (prga_key == tgt) ? tb2 : ob2;
      endcase
    end
  end

  always @(negedge clk) if (init_en) n_init++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_msg(input logic [23:0] t, input logic [7:0] l, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] o1, input logic [7:0] o2);
    tgt = t; len = l; tb1 = a1; tb2 = a2; ob1 = o1; ob2 = o2;
  endtask

  // Pulse en from IDLE/DONE; leaves the bench at the INIT_GO negedge
  task automatic start(input string tag);
    @(negedge clk);
    n_init = 0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check({tag, "_rdy_drop"}, 32'(rdy), 32'h0);
    check({tag, "_init_en"}, 32'(init_en), 32'h1);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < BOUND; i++) begin
      if (rdy) break;
      @(negedge clk);
    end
    check({tag, "_done_timeout"}, 32'(rdy), 32'h1);
  endtask

  // Wait for a one-cycle enable pulse: 0=init, 1=ksa, 2=prga
  task automatic wait_en(input string tag, input int which);
    int i;
    logic hit;
    hit = 1'b0;
    for (i = 0; i < BOUND && !hit; i++) begin
      @(negedge clk);
      hit = (which == 0) ? init_en : (which == 1) ? ksa_en : prga_en;
    end
    if (!hit) check({tag, "_en_timeout"}, 32'(hit), 32'h1);
  endtask

  task automatic run_and_expect(input string tag, input logic [23:0] k, input logic v, input int ninit);
    start(tag);
    wait_done(tag);
    check({tag, "_key"}, 32'(key), 32'(k));
    check({tag, "_key_valid"}, 32'(key_valid), 32'(v));
    check({tag, "_init_pulses"}, 32'(n_init), 32'(ninit));
  endtask

  initial begin
    // Reset held for two edges
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'h1);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_s_wren", 32'(s_wren), 32'h0);
    check("rst_init_en", 32'(init_en), 32'h0);
    check("rst_ksa_en", 32'(ksa_en), 32'h0);
    check("rst_prga_en", 32'(prga_en), 32'h0);
    check("rst_key", 32'(key), 32'(K_FIRST));
    rst_n = 1'b1;

    // Find key 2: "Hi" only for key 2, 0x01 elsewhere
    set_msg(24'h2, 8'h02, 8'h48, 8'h69, 8'h01, 8'h01);
    run_and_expect("find", 24'h2, 1'b1, 3);
    check("find_ksa_key", 32'(ksa_key), 32'h2);
    check("find_prga_key", 32'(prga_key), 32'h2);

    // Exhausted range with mux and en-while-busy probes
    set_msg(24'h0, 8'h02, 8'h80, 8'h80, 8'h80, 8'h80);
    start("exh");
    wait_en("exh_ksa", 1);
    @(negedge clk);
    check("mux_ksa_addr", 32'(s_addr), 32'h10);
    check("mux_ksa_wren", 32'(s_wren), 32'h1);
    check("mux_ksa_wrdata", 32'(s_wrdata), 32'hB2);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("busy_en_rdy", 32'(rdy), 32'h0);
    check("busy_en_key", 32'(key), 32'h0);
    check("busy_en_ksa_mux", 32'(s_addr), 32'h10);
    wait_en("exh_prga", 2);
    begin
      int i;
      for (i = 0; i < BOUND; i++) begin
        @(negedge clk);
        if (prga_rdy) break;
      end
    end
    check("mux_prga_addr", 32'(s_addr), 32'h30);
    @(negedge clk);
    check("mux_check_wren", 32'(s_wren), 32'h0);
    check("mux_check_addr", 32'(s_addr), 32'h00);
    @(negedge clk);
    check("next_init_en", 32'(init_en), 32'h1);
    check("next_key", 32'(key), 32'h1);
    check("mux_init_addr", 32'(s_addr), 32'h20);
    wait_done("exh");
    check("exh_key", 32'(key), 32'h3);
    check("exh_key_valid", 32'(key_valid), 32'h0);
    check("exh_init_pulses", 32'(n_init), 32'd4);

    // Printable bounds; other keys always 'A'
    set_msg(24'h0, 8'h02, 8'h20, 8'h7E, 8'h41, 8'h41);
    run_and_expect("lo_hi_ok", 24'h0, 1'b1, 1);
    set_msg(24'h0, 8'h02, 8'h1F, 8'h41, 8'h41, 8'h41);
    run_and_expect("below_20", 24'h1, 1'b1, 2);
    set_msg(24'h0, 8'h02, 8'h41, 8'h7F, 8'h41, 8'h41);
    run_and_expect("above_7e", 24'h1, 1'b1, 2);
    set_msg(24'h0, 8'h00, 8'h41, 8'h41, 8'h41, 8'h41);
    run_and_expect("len_zero", 24'h0, 1'b1, 1);

    // Reset during PRGA_WAIT of key 1
    set_msg(24'h0, 8'h02, 8'h80, 8'h80, 8'h80, 8'h80);
    start("rstmid");
    wait_en("rstmid_p0", 2);
    wait_en("rstmid_p1", 2);
    @(negedge clk);
    check("rstmid_key_before", 32'(key), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_rdy", 32'(rdy), 32'h1);
    check("rstmid_prga_en", 32'(prga_en), 32'h0);
    check("rstmid_key", 32'(key), 32'(K_FIRST));
    check("rstmid_s_wren", 32'(s_wren), 32'h0);

    // Search still works after the abandoned run
    set_msg(24'h2, 8'h02, 8'h48, 8'h69, 8'h01, 8'h01);
    run_and_expect("refind", 24'h2, 1'b1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
